// File: rtl/ysyx_22040895_memarb.sv
// Memory port arbiter: shares one valid/ready memory port between fetch (IF) and load/store (LS).
// Optional response watchdog compiled in with `define YSYX_22040895_MEMARB_TIMEOUT_EN.
module ysyx_22040895_memarb #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_done_o,
  output logic [31:0]         if_rdata_o,
  input  logic                ls_req_i,
  input  logic                ls_we_i,
  input  logic [ADDR_W-1:0]   ls_addr_i,
  input  logic [DATA_W-1:0]   ls_wdata_i,
  input  logic [DATA_W/8-1:0] ls_wmask_i,
  output logic                ls_done_o,
  output logic [DATA_W-1:0]   ls_rdata_o,
  output logic                mem_valid_o,
  input  logic                mem_ready_i,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_wmask_o,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic                stall_o,
  output logic                err_o
);

  // state  | meaning
  // IDLE   | no access; arbitrate (LS over IF) and latch command
  // ADDR   | address phase, mem_valid_o high until mem_ready_i
  // DATA   | waiting for read data (mem_rvalid_i)
  // RESP   | one-cycle done pulse to the owner
  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

  state_t r_state;
  state_t w_next;

  logic                r_owner_ls;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W/8-1:0] r_wmask;
  logic [31:0]         r_if_rdata;
  logic [DATA_W-1:0]   r_ls_rdata;

  logic w_finish;
  logic w_capture;
  logic w_timeout;

  // Read data is only taken for loads/fetches, and only once the address phase was accepted.
  assign w_capture = ((r_state == S_ADDR) && mem_ready_i && !r_we && mem_rvalid_i) ||
                     ((r_state == S_DATA) && mem_rvalid_i);
  assign w_finish  = w_capture || ((r_state == S_ADDR) && mem_ready_i && r_we);

`ifdef YSYX_22040895_MEMARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CNT_W-1:0] r_wdog;
  logic             r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wdog <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err <= w_timeout;
      if (r_state == S_IDLE)
        r_wdog <= '0;
      else if ((r_state == S_ADDR) || (r_state == S_DATA))
        r_wdog <= r_wdog + 1'b1;
    end
  end

  assign w_timeout = ((r_state == S_ADDR) || (r_state == S_DATA)) &&
                     (r_wdog == CNT_W'(TIMEOUT - 1)) && !w_finish;
  assign err_o     = r_err;
`else
  assign w_timeout = 1'b0;
  assign err_o     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (ls_req_i || if_req_i) w_next = S_ADDR;
      S_ADDR: begin
        if (w_finish)         w_next = S_RESP;
        else if (w_timeout)   w_next = S_RESP;
        else if (mem_ready_i) w_next = S_DATA;
      end
      S_DATA: if (w_finish || w_timeout) w_next = S_RESP;
      S_RESP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    mem_valid_o = 1'b0;
    stall_o     = 1'b0;
    if_done_o   = 1'b0;
    ls_done_o   = 1'b0;
    case (r_state)
      S_IDLE: stall_o = if_req_i || ls_req_i;
      S_ADDR: begin
        mem_valid_o = 1'b1;
        stall_o     = 1'b1;
      end
      S_DATA: stall_o = 1'b1;
      S_RESP: begin
        if_done_o = !r_owner_ls;
        ls_done_o = r_owner_ls;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner_ls <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wmask    <= '0;
      r_if_rdata <= '0;
      r_ls_rdata <= '0;
    end else begin
      if (r_state == S_IDLE) begin
        if (ls_req_i) begin
          r_owner_ls <= 1'b1;
          r_we       <= ls_we_i;
          r_addr     <= ls_addr_i;
          r_wdata    <= ls_wdata_i;
          r_wmask    <= ls_wmask_i;
        end else if (if_req_i) begin
          r_owner_ls <= 1'b0;
          r_we       <= 1'b0;
          r_addr     <= if_addr_i;
          r_wdata    <= '0;
          r_wmask    <= '0;
        end
      end
      if (w_capture) begin
        if (r_owner_ls) r_ls_rdata <= mem_rdata_i;
        else            r_if_rdata <= mem_rdata_i[31:0];
      end
      if ((r_state == S_ADDR) && mem_ready_i && r_we)
        r_ls_rdata <= '0;
      // An aborted access reports zero data to its owner.
      if (w_timeout) begin
        if (r_owner_ls) r_ls_rdata <= '0;
        else            r_if_rdata <= '0;
      end
    end
  end

  assign mem_we_o    = r_we;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;
  assign mem_wmask_o = r_wmask;
  assign if_rdata_o  = r_if_rdata;
  assign ls_rdata_o  = r_ls_rdata;

endmodule
